// File: rtl/muldiv_unit_pkg.sv
// Shared types and helpers for the RV64M
// multiply/divide unit.
package muldiv_unit_pkg;

  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    MULDIV_MUL    = 3'd0,
    MULDIV_MULH   = 3'd1,
    MULDIV_MULHSU = 3'd2,
    MULDIV_MULHU  = 3'd3,
    MULDIV_DIV    = 3'd4,
    MULDIV_DIVU   = 3'd5,
    MULDIV_REM    = 3'd6,
    MULDIV_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } md_state_t;

  function automatic logic isSignedDiv(
    input logic [2:0] op
  );
    return op[2] & ~op[0];
  endfunction

  function automatic logic isRem(
    input logic [2:0] op
  );
    return op[2] & op[1];
  endfunction

  function automatic logic [XLEN-1:0] wordExt(
    input logic [XLEN-1:0] v,
    input logic            sgn
  );
    return {{(XLEN-32){sgn & v[31]}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] minVal(
    input logic w
  );
    return w ? {{(XLEN-31){1'b1}}, 31'b0}
             : {1'b1, {(XLEN-1){1'b0}}};
  endfunction

  // Divide by zero or signed min / -1.
  function automatic logic divSpecial(
    input logic [2:0]      op,
    input logic [XLEN-1:0] x,
    input logic [XLEN-1:0] y,
    input logic            w
  );
    return (y == '0)
         | (isSignedDiv(op) & (y == '1)
            & (x == minVal(w)));
  endfunction

endpackage

// File: rtl/muldiv_unit_divider_iter.sv
// Restoring radix-2 unsigned divider, one
// quotient bit per clock; first bit on start.
module muldiv_unit_divider_iter
  import muldiv_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [6:0]      nbits,
  output logic            done,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  logic [XLEN-1:0] remQ, quotQ, dvsQ;
  logic [6:0]      cnt;

  function automatic logic [2*XLEN-1:0] step(
    input logic [XLEN-1:0] r,
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] d
  );
    logic [XLEN:0] t;
    logic [XLEN:0] diff;
    t    = {r, q[XLEN-1]};
    diff = t - {1'b0, d};
    if (!diff[XLEN])
      return {diff[XLEN-1:0], q[XLEN-2:0], 1'b1};
    return {t[XLEN-1:0], q[XLEN-2:0], 1'b0};
  endfunction

  // Narrow ops are left-aligned so only the
  // top nbits of the dividend are consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remQ  <= '0;
      quotQ <= '0;
      dvsQ  <= '0;
      cnt   <= '0;
    end else if (start) begin
      {remQ, quotQ} <= step('0,
        dividend << (7'(XLEN) - nbits), divisor);
      dvsQ <= divisor;
      cnt  <= nbits - 7'd1;
    end else if (cnt != '0) begin
      {remQ, quotQ} <= step(remQ, quotQ, dvsQ);
      cnt <= cnt - 7'd1;
    end
  end

  assign done = (cnt == '0);
  assign quot = quotQ;
  assign rem  = remQ;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV64M multiply/divide unit for
// the execute stage; holds result until accept.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [2:0]      op,
  input  logic            is_word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            accept,
  input  logic            flush,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stallE
);

  localparam int PW = 2 * XLEN;
  localparam logic [7:0] MUL_LAST =
    8'(MUL_LAT - 1);

  md_state_t       state, stateNext;
  logic [7:0]      cnt;
  logic [2:0]      opQ;
  logic            wordQ;
  logic [XLEN-1:0] opA, opB;
  logic [XLEN-1:0] inA, inB, magA, magB;
  logic            sgnIn, signA, signB;
  logic            special, divStart;
  logic [PW-1:0]   mulA, mulB, prodTop;
  logic [PW-1:0]   prodPipe [MUL_LAT];
  logic            divDone;
  logic [XLEN-1:0] divQuot, divRem;
  logic [XLEN-1:0] quot, rem, mulRes, divRes;
  logic            negQ, negR;

  assign stallE = valid_in & ~done;

  always_comb begin
    sgnIn = (op != MULDIV_DIVU)
         && (op != MULDIV_REMU);
    inA = is_word ? wordExt(a, sgnIn) : a;
    inB = is_word ? wordExt(b, sgnIn) : b;
    signA = (op != MULDIV_MULHU);
    signB = (op == MULDIV_MUL)
         || (op == MULDIV_MULH);
    mulA = {{XLEN{signA & inA[XLEN-1]}}, inA};
    mulB = {{XLEN{signB & inB[XLEN-1]}}, inB};
    magA = (isSignedDiv(op) && inA[XLEN-1])
         ? -inA : inA;
    magB = (isSignedDiv(op) && inB[XLEN-1])
         ? -inB : inB;
    special = divSpecial(op, inA, inB, is_word);
  end

  assign divStart = (state == S_IDLE) & valid_in
                  & ~flush & op[2] & ~special;

  // Product enters the chain on the issue edge.
  always_ff @(posedge clk) begin
    prodPipe[0] <= mulA * mulB;
    for (int i = 1; i < MUL_LAT; i++)
      prodPipe[i] <= prodPipe[i-1];
    if (state == S_IDLE) begin
      opQ   <= op;
      wordQ <= is_word;
      opA   <= inA;
      opB   <= inB;
    end
  end

  assign prodTop = prodPipe[MUL_LAT-1];

  muldiv_unit_divider_iter u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (divStart),
    .dividend (magA),
    .divisor  (magB),
    .nbits    (is_word ? 7'd32 : 7'(XLEN)),
    .done     (divDone),
    .quot     (divQuot),
    .rem      (divRem)
  );

  always_comb begin
    mulRes = (opQ == MULDIV_MUL)
           ? prodTop[XLEN-1:0]
           : prodTop[PW-1:XLEN];
    if (wordQ) mulRes = wordExt(mulRes, 1'b1);
    negQ = isSignedDiv(opQ)
         & (opA[XLEN-1] ^ opB[XLEN-1]);
    negR = isSignedDiv(opQ) & opA[XLEN-1];
    quot = negQ ? -divQuot : divQuot;
    rem  = negR ? -divRem : divRem;
    if (opB == '0) begin
      quot = '1;
      rem  = opA;
    end else if (divSpecial(opQ, opA, opB,
                            wordQ)) begin
      quot = minVal(wordQ);
      rem  = '0;
    end
    divRes = isRem(opQ) ? rem : quot;
    if (wordQ) divRes = wordExt(divRes, 1'b1);
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      S_IDLE:
        if (valid_in)
          stateNext = !op[2] ? S_MUL
                    : special ? S_FIX : S_DIV;
      S_MUL:
        if (cnt == MUL_LAST) stateNext = S_DONE;
      S_DIV:
        if (divDone) stateNext = S_FIX;
      S_FIX:
        stateNext = S_DONE;
      S_DONE:
        if (accept) stateNext = S_IDLE;
      default:
        stateNext = S_IDLE;
    endcase
    if (flush) stateNext = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
    end else begin
      done <= (stateNext == S_DONE);
      cnt  <= (state == S_MUL) ? cnt + 8'd1 : '0;
      if (stateNext == S_DONE) begin
        if (state == S_MUL) result <= mulRes;
        if (state == S_FIX) result <= divRes;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: spec
// vectors, hold, flush, reset and random ops.
module tb_muldiv_unit;

  localparam logic [63:0] ONES =
    64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] M20 =
    64'hFFFF_FFFF_FFFF_FFEC;

  typedef struct packed {
    logic [63:0] res;
    int          lat;
  } exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
  } stim_t;

  logic        clk = 0;
  logic        reset = 1;
  logic        valid_in = 0;
  logic [2:0]  op = 0;
  logic        is_word = 0;
  logic [63:0] a = 0;
  logic [63:0] b = 0;
  logic        accept = 1;
  logic        flush = 0;
  logic        done;
  logic [63:0] result;
  logic        stallE;

  exp_t sb[$];
  int   nCmp = 0;
  int   nBad = 0;

  muldiv_unit #(.MUL_LAT(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .op       (op),
    .is_word  (is_word),
    .a        (a),
    .b        (b),
    .accept   (accept),
    .flush    (flush),
    .done     (done),
    .result   (result),
    .stallE   (stallE)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] cond(
    input logic [2:0] o, input logic w,
    input logic [63:0] v);
    if (!w) return v;
    if (o == 3'd5 || o == 3'd7)
      return {32'b0, v[31:0]};
    return {{32{v[31]}}, v[31:0]};
  endfunction

  function automatic logic [63:0] model(
    input logic [2:0] o, input logic w,
    input logic [63:0] a0, input logic [63:0] b0);
    logic [63:0]  x, y, r;
    logic [127:0] p, xs, ys, xz, yz;
    x  = cond(o, w, a0);
    y  = cond(o, w, b0);
    xs = {{64{x[63]}}, x};
    ys = {{64{y[63]}}, y};
    xz = {64'b0, x};
    yz = {64'b0, y};
    r  = '0;
    case (o)
      3'd0: begin p = xs * ys; r = p[63:0]; end
      3'd1: begin p = xs * ys; r = p[127:64]; end
      3'd2: begin p = xs * yz; r = p[127:64]; end
      3'd3: begin p = xz * yz; r = p[127:64]; end
      3'd4, 3'd6: begin
        if (y == 0)
          r = (o == 3'd4) ? ONES : x;
        else if (x == 64'h8000_0000_0000_0000
                 && y == ONES)
          r = (o == 3'd4) ? x : 64'd0;
        else if (o == 3'd4)
          r = $signed(x) / $signed(y);
        else
          r = $signed(x) % $signed(y);
      end
      default: begin
        if (y == 0)
          r = (o == 3'd5) ? ONES : x;
        else
          r = (o == 3'd5) ? x / y : x % y;
      end
    endcase
    if (w) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  function automatic int latOf(
    input logic [2:0] o, input logic w,
    input logic [63:0] a0, input logic [63:0] b0);
    logic [63:0] x, y, mn;
    if (!o[2]) return 4;
    x  = cond(o, w, a0);
    y  = cond(o, w, b0);
    mn = w ? 64'hFFFF_FFFF_8000_0000
           : 64'h8000_0000_0000_0000;
    if (y == 0) return 2;
    if ((o == 3'd4 || o == 3'd6)
        && y == ONES && x == mn) return 2;
    return w ? 34 : 66;
  endfunction

  function automatic stim_t mk(
    input logic [2:0] o, input logic w,
    input logic [63:0] x, input logic [63:0] y,
    input logic [63:0] r);
    stim_t s;
    s.op = o; s.w = w; s.a = x; s.b = y;
    s.res = r;
    return s;
  endfunction

  // Drive one op with accept=1; report result,
  // cycles from issue to done, stallE behaviour.
  task automatic execute(
    input logic [2:0] o, input logic w,
    input logic [63:0] x, input logic [63:0] y,
    output logic [63:0] res, output int lat,
    output logic stallOk);
    valid_in = 1; op = o; is_word = w;
    a = x; b = y; accept = 1;
    #1;
    stallOk = (stallE === 1'b1);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (stallE !== 1'b1) stallOk = 0;
    end
    res = result;
    if (stallE !== 1'b0) stallOk = 0;
    @(posedge clk); #1;
    valid_in = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    nCmp++;
    if (done !== 0 || result !== 0
        || stallE !== 0) begin
      nBad++;
      $display("FAIL reset: done=%b result=%h stallE=%b, want 0/0/0",
               done, result, stallE);
    end
    valid_in = 1; #1;
    nCmp++;
    if (stallE !== 1'b1) begin
      nBad++;
      $display("FAIL reset_stall: stallE=%b, want 1",
               stallE);
    end
    valid_in = 0;
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_table(input string nm,
                            input stim_t t[$]);
    logic [63:0] res;
    int          lat;
    logic        st;
    exp_t        e;
    foreach (t[i]) begin
      sb.push_back('{res: t[i].res,
        lat: latOf(t[i].op, t[i].w,
                   t[i].a, t[i].b)});
      execute(t[i].op, t[i].w, t[i].a, t[i].b,
              res, lat, st);
      e = sb.pop_front();
      nCmp++;
      if (res !== e.res || lat != e.lat
          || st !== 1'b1) begin
        nBad++;
        $display("FAIL %s[%0d]: result=%h lat=%0d stall=%b, want %h lat=%0d stall=1",
                 nm, i, res, lat, st, e.res, e.lat);
      end
    end
  endtask

  task automatic test_mul();
    stim_t t[$];
    t.push_back(mk(3'd0, 0, 64'd7,
      64'hFFFF_FFFF_FFFF_FFFD,
      64'hFFFF_FFFF_FFFF_FFEB));
    t.push_back(mk(3'd3, 0, ONES, ONES,
      64'hFFFF_FFFF_FFFF_FFFE));
    t.push_back(mk(3'd1, 0, ONES, ONES, 64'd0));
    t.push_back(mk(3'd2, 0, ONES, 64'd2, ONES));
    test_table("mul", t);
  endtask

  task automatic test_div();
    stim_t t[$];
    t.push_back(mk(3'd4, 0, M20, 64'd6,
      64'hFFFF_FFFF_FFFF_FFFD));
    t.push_back(mk(3'd6, 0, M20, 64'd6,
      64'hFFFF_FFFF_FFFF_FFFE));
    t.push_back(mk(3'd5, 0, 64'd20, 64'd6, 64'd3));
    t.push_back(mk(3'd7, 1,
      64'h1_0000_0005, 64'd3, 64'd2));
    test_table("div", t);
  endtask

  task automatic test_special();
    stim_t t[$];
    t.push_back(mk(3'd4, 0, 64'd5, 64'd0, ONES));
    t.push_back(mk(3'd6, 0, 64'd5, 64'd0, 64'd5));
    t.push_back(mk(3'd4, 1, 64'h8000_0000, ONES,
      64'hFFFF_FFFF_8000_0000));
    t.push_back(mk(3'd6, 1, 64'h8000_0000, ONES,
      64'd0));
    t.push_back(mk(3'd4, 0,
      64'h8000_0000_0000_0000, ONES,
      64'h8000_0000_0000_0000));
    test_table("special", t);
  endtask

  task automatic test_hold();
    int   lat;
    exp_t e;
    stim_t t[$];
    sb.push_back('{res: 64'hFFFF_FFFF_FFFF_FFFD,
                   lat: 66});
    valid_in = 1; op = 3'd4; is_word = 0;
    a = M20; b = 64'd6; accept = 0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    e = sb.pop_front();
    nCmp++;
    if (lat != e.lat || result !== e.res) begin
      nBad++;
      $display("FAIL hold_first: result=%h lat=%0d, want %h lat=%0d",
               result, lat, e.res, e.lat);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      nCmp++;
      if (done !== 1'b1 || result !== e.res
          || stallE !== 1'b0) begin
        nBad++;
        $display("FAIL hold[%0d]: done=%b result=%h stallE=%b, want 1/%h/0",
                 k, done, result, stallE, e.res);
      end
    end
    accept = 1;
    @(posedge clk); #1;
    valid_in = 0;
    nCmp++;
    if (done !== 1'b0) begin
      nBad++;
      $display("FAIL hold_release: done=%b, want 0",
               done);
    end
    t.push_back(mk(3'd0, 0, 64'd7,
      64'hFFFF_FFFF_FFFF_FFFD,
      64'hFFFF_FFFF_FFFF_FFEB));
    test_table("after_hold", t);
  endtask

  task automatic test_flush();
    logic [63:0] prev;
    logic        seen;
    stim_t       t[$];
    prev = result;
    valid_in = 1; op = 3'd4; is_word = 0;
    a = M20; b = 64'd6; accept = 1;
    repeat (10) @(posedge clk);
    #1;
    flush = 1;
    @(posedge clk); #1;
    flush = 0; valid_in = 0;
    nCmp++;
    if (done !== 1'b0 || result !== prev) begin
      nBad++;
      $display("FAIL flush_now: done=%b result=%h, want 0/%h",
               done, result, prev);
    end
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen = 1;
    end
    nCmp++;
    if (seen !== 1'b0) begin
      nBad++;
      $display("FAIL flush_quiet: done seen=%b, want 0",
               seen);
    end
    t.push_back(mk(3'd5, 0, 64'd100, 64'd7,
      64'd14));
    test_table("after_flush", t);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  o;
    logic        w;
    logic [63:0] x, y;
    stim_t       t[$];
    for (int i = 0; i < 10; i++) begin
      o = 3'($urandom_range(0, 7));
      w = (o == 3'd0 || o[2])
        ? 1'($urandom_range(0, 1)) : 1'b0;
      x = {$urandom, $urandom};
      y = (i % 3 == 0) ? 64'($urandom_range(1, 9))
                       : {$urandom, $urandom};
      if (i == 4) x = -x;
      t.push_back(mk(o, w, x, y,
                     model(o, w, x, y)));
    end
    test_table("b2b", t);
    nCmp++;
    if (done !== 1'b0) begin
      nBad++;
      $display("FAIL b2b_idle: done=%b, want 0",
               done);
    end
  endtask

  task automatic test_async_reset();
    logic seen;
    stim_t t[$];
    t.push_back(mk(3'd0, 0, 64'd5, 64'd5, 64'd25));
    test_table("pre_reset", t);
    valid_in = 1; op = 3'd0; is_word = 0;
    a = 64'd9; b = 64'd9;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1;
    #1;
    nCmp++;
    if (done !== 1'b0 || result !== 64'd0) begin
      nBad++;
      $display("FAIL async_reset: done=%b result=%h, want 0/0",
               done, result);
    end
    @(negedge clk);
    reset = 0; valid_in = 0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen = 1;
    end
    nCmp++;
    if (seen !== 1'b0) begin
      nBad++;
      $display("FAIL reset_quiet: done seen=%b, want 0",
               seen);
    end
    t.delete();
    t.push_back(mk(3'd0, 1, 64'h0000_0001_0001_0000,
      64'h1_0000, 64'd0));
    test_table("after_reset", t);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_hold();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
